// File: rtl/xpe_layer_seq.sv
// xpe_layer_seq
// Per-layer sequencer for the XPE post-processing datapath. Accepts one layer
// descriptor, optionally streams the activation LUT into the LUT BRAM port,
// holds the XPE configuration and calc enable while counting output vectors,
// then pulses calculate_end, waits for the XPE pipeline to drain and pulses done.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_abort                 synchronous abort back to IDLE
//   i_cfg_* / o_cfg_rdy     layer descriptor handshake
//   i_lut_* / o_lut_rdy     activation-LUT entry stream
//   o_lut_bramctl_*         LUT BRAM controller write port
//   o_mode, o_xpe_mode,
//   o_actfun_en, o_calc_en  configuration and enable towards the XPE
//   i_xpe_dat_vld           XPE output-vector valid
//   o_calculate_end, o_done end-of-layer and layer-complete pulses
//   o_busy, o_err           not-idle status, sticky unexpected-valid flag
module xpe_layer_seq #(
    parameter int LUT_DEPTH = 32,
    parameter int LUT_AW    = 5,
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 6
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_abort,
    input  logic              i_cfg_vld,
    output logic              o_cfg_rdy,
    input  logic [3:0]        i_cfg_mode,
    input  logic [1:0]        i_cfg_xpe_mode,
    input  logic              i_cfg_actfun_en,
    input  logic              i_cfg_lut_load,
    input  logic [CNT_W-1:0]  i_cfg_out_cnt,
    input  logic [23:0]       i_lut_wdata,
    input  logic              i_lut_vld,
    output logic              o_lut_rdy,
    output logic [23:0]       o_lut_bramctl_wdata,
    output logic [LUT_AW-1:0] o_lut_bramctl_addr,
    output logic              o_lut_bramctl_we,
    output logic              o_lut_bramctl_en,
    output logic [3:0]        o_mode,
    output logic [1:0]        o_xpe_mode,
    output logic              o_actfun_en,
    output logic              o_calc_en,
    input  logic              i_xpe_dat_vld,
    output logic              o_calculate_end,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    typedef enum logic [2:0] {ST_IDLE, ST_LUT, ST_RUN, ST_END, ST_DRAIN} state_t;

    localparam int                DRN_W      = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);
    localparam logic [DRN_W-1:0]  DRAIN_LOAD = DRN_W'(DRAIN_CYC);
    localparam logic [LUT_AW-1:0] LUT_LAST   = LUT_AW'(LUT_DEPTH - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  out_cnt_q, vec_cnt;
    logic [LUT_AW-1:0] lut_idx;
    logic [DRN_W-1:0]  drain_cnt, drain_nxt;

    logic cfg_acc, lut_beat, vec_room, vec_hit, err_set;
    logic cfg_rdy_d, busy_d, lut_rdy_d, calc_en_d, calc_end_d, done_d;

    assign cfg_acc  = i_cfg_vld && (state == ST_IDLE) && !i_abort;
    assign lut_beat = i_lut_vld && (state == ST_LUT) && !i_abort;
    // A valid is only legitimate while running with the count still unsatisfied.
    assign vec_room = (state == ST_RUN) && (vec_cnt != out_cnt_q);
    assign vec_hit  = i_xpe_dat_vld && vec_room && ((vec_cnt + CNT_W'(1)) == out_cnt_q);
    assign err_set  = i_xpe_dat_vld && !vec_room;

    // State register and drain counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_nxt = state;
        drain_nxt = drain_cnt;
        if (i_abort) begin
            state_nxt = ST_IDLE;
            drain_nxt = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_cfg_vld) begin
                        if (i_cfg_lut_load)
                            state_nxt = ST_LUT;
                        else if (i_cfg_out_cnt == '0)
                            state_nxt = ST_END;
                        else
                            state_nxt = ST_RUN;
                    end
                end
                ST_LUT: begin
                    if (lut_beat && (lut_idx == LUT_LAST))
                        state_nxt = (out_cnt_q == '0) ? ST_END : ST_RUN;
                end
                ST_RUN: begin
                    if (vec_hit)
                        state_nxt = ST_END;
                end
                ST_END: begin
                    state_nxt = ST_DRAIN;
                    drain_nxt = DRAIN_LOAD;
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0)
                        state_nxt = ST_IDLE;
                    else
                        drain_nxt = drain_cnt - DRN_W'(1);
                end
                default: begin
                    state_nxt = ST_IDLE;
                    drain_nxt = '0;
                end
            endcase
        end
    end

    // Output decode from the next state, so the registered outputs line up
    // with the state they describe. Done fires in the DRAIN cycle whose count is 0.
    always_comb begin
        cfg_rdy_d  = (state_nxt == ST_IDLE);
        busy_d     = (state_nxt != ST_IDLE);
        lut_rdy_d  = (state_nxt == ST_LUT);
        calc_en_d  = (state_nxt == ST_RUN);
        calc_end_d = (state_nxt == ST_END);
        done_d     = (state_nxt == ST_DRAIN) && (drain_nxt == '0);
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_cnt_q           <= '0;
            vec_cnt             <= '0;
            lut_idx             <= '0;
            o_cfg_rdy           <= 1'b1;
            o_busy              <= 1'b0;
            o_lut_rdy           <= 1'b0;
            o_calc_en           <= 1'b0;
            o_calculate_end     <= 1'b0;
            o_done              <= 1'b0;
            o_err               <= 1'b0;
            o_mode              <= '0;
            o_xpe_mode          <= '0;
            o_actfun_en         <= 1'b0;
            o_lut_bramctl_we    <= 1'b0;
            o_lut_bramctl_en    <= 1'b0;
            o_lut_bramctl_addr  <= '0;
            o_lut_bramctl_wdata <= '0;
        end else begin
            o_cfg_rdy       <= cfg_rdy_d;
            o_busy          <= busy_d;
            o_lut_rdy       <= lut_rdy_d;
            o_calc_en       <= calc_en_d;
            o_calculate_end <= calc_end_d;
            o_done          <= done_d;

            if (i_abort) begin
                vec_cnt <= '0;
                lut_idx <= '0;
            end else if (cfg_acc) begin
                out_cnt_q   <= i_cfg_out_cnt;
                o_mode      <= i_cfg_mode;
                o_xpe_mode  <= i_cfg_xpe_mode;
                o_actfun_en <= i_cfg_actfun_en;
                vec_cnt     <= '0;
                lut_idx     <= '0;
            end else begin
                // The index parks on the last entry instead of wrapping.
                if (lut_beat && (lut_idx != LUT_LAST))
                    lut_idx <= lut_idx + LUT_AW'(1);
                if (i_xpe_dat_vld && vec_room)
                    vec_cnt <= vec_cnt + CNT_W'(1);
            end

            // An unexpected valid in the accept cycle still counts against the new layer.
            if (err_set)
                o_err <= 1'b1;
            else if (cfg_acc)
                o_err <= 1'b0;

            o_lut_bramctl_we <= lut_beat;
            o_lut_bramctl_en <= lut_beat;
            if (lut_beat) begin
                o_lut_bramctl_addr  <= lut_idx;
                o_lut_bramctl_wdata <= i_lut_wdata;
            end
        end
    end

endmodule

// File: doc/xpe_layer_seq.md
Name: xpe_layer_seq

Overview:
Per-layer sequencer for the XPE post-processing datapath (bias, relu, round, activation LUT, avg-pool scale). It accepts one layer descriptor through a valid/ready handshake. If the descriptor requests it, the block streams 32 activation-LUT entries into the LUT BRAM controller port. It then holds the datapath configuration and calc enable while counting output vectors. When the count is reached it pulses calculate_end, waits for the pipeline to drain, and reports done. It sits between the NPU layer controller and the XPE instance.

Parameters:
LUT_DEPTH, 32, number of activation-LUT entries loaded per LUT load
LUT_AW, 5, LUT address width; must satisfy 2**LUT_AW == LUT_DEPTH
CNT_W, 16, width of the output-vector counter
DRAIN_CYC, 6, cycles waited after calculate_end before done (covers the deepest XPE valid pipeline)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_abort  in  1  synchronous abort; returns the block to IDLE
i_cfg_vld  in  1  descriptor valid
o_cfg_rdy  out  1  descriptor ready; high only in IDLE
i_cfg_mode  in  4  layer mode (1 conv, 2 fc, 3 add, 4 pool, 5 avg pool, 6 matrix, 8 dotacc)
i_cfg_xpe_mode  in  2  activation select (0 none, 1 relu, 2 sigmoid, 3 tanh)
i_cfg_actfun_en  in  1  activation-only pass enable
i_cfg_lut_load  in  1  load the LUT before RUN
i_cfg_out_cnt  in  CNT_W  number of output vectors expected
i_lut_wdata  in  24  LUT entry stream data
i_lut_vld  in  1  LUT entry valid
o_lut_rdy  out  1  LUT entry ready; high only in LUT
o_lut_bramctl_wdata  out  24  LUT write data
o_lut_bramctl_addr  out  LUT_AW  LUT write address
o_lut_bramctl_we  out  1  LUT write enable
o_lut_bramctl_en  out  1  LUT enable
o_mode  out  4  latched mode, to the XPE
o_xpe_mode  out  2  latched activation select, to the XPE
o_actfun_en  out  1  latched activation-only enable, to the XPE
o_calc_en  out  1  datapath calc enable
i_xpe_dat_vld  in  1  XPE output-vector valid
o_calculate_end  out  1  one-cycle end-of-layer pulse
o_busy  out  1  high whenever the state is not IDLE
o_done  out  1  one-cycle layer-complete pulse
o_err  out  1  sticky unexpected-valid flag

Behaviour:
- Reset: all outputs are 0, except o_cfg_rdy, which is 1 because the reset state is IDLE. The output-vector counter and the LUT index reset to 0.
- All outputs are registered.
- States: IDLE, LUT, RUN, END, DRAIN.
- IDLE:
  - On i_cfg_vld && o_cfg_rdy, latch mode, xpe_mode, actfun_en and out_cnt; clear o_err, the counter and the LUT index.
  - Next state is LUT if i_cfg_lut_load is 1; otherwise RUN.
  - If out_cnt is 0 and no LUT load is requested, go directly to END.
- LUT:
  - o_lut_rdy = 1.
  - Each beat with i_lut_vld high produces, one cycle later, o_lut_bramctl_we = o_lut_bramctl_en = 1, wdata = the beat's data, addr = the LUT index. The index then increments.
  - Gaps in i_lut_vld are allowed; we and en are 0 on cycles with no pending write.
  - When the beat at index LUT_DEPTH-1 is accepted, o_lut_rdy drops in the following cycle. Next state is RUN, or END if out_cnt is 0.
  - The index does not wrap within a load.
- RUN:
  - o_calc_en = 1. Each cycle with i_xpe_dat_vld high increments the counter.
  - The valid that brings the count to out_cnt moves the state to END in the next cycle; o_calc_en falls in that same cycle.
- END:
  - Exactly one cycle. o_calculate_end = 1, o_calc_en = 0.
  - Next state is DRAIN with the drain counter set to DRAIN_CYC.
- DRAIN:
  - Decrement the drain counter each cycle. At 0, pulse o_done and return to IDLE.
  - o_cfg_rdy is 1 in the cycle after the o_done pulse.
- o_err is set by:
  - i_xpe_dat_vld in IDLE or LUT;
  - i_xpe_dat_vld in END or DRAIN;
  - a valid arriving after the count is already satisfied.
  - Extra valids never change the counter. o_err stays set until the next descriptor is accepted.
- Configuration outputs (o_mode, o_xpe_mode, o_actfun_en) hold their latched values until the next descriptor is accepted, including through IDLE.
- i_abort has priority over all transitions. From any state, go to IDLE next cycle:
  - o_calc_en, we, en and o_lut_rdy deassert;
  - no o_calculate_end and no o_done are issued;
  - counters clear; configuration outputs are kept.
- An asynchronous reset mid-LUT or mid-RUN behaves the same as power-on reset.
- Counter arithmetic is unsigned CNT_W; the valid comparison is counter+1 == out_cnt.

Test Plan:
1. Conv layer, mode=1, xpe_mode=1, lut_load=0, out_cnt=4, with 4 valid pulses spaced 2 cycles apart -> o_calc_en high from the cycle after accept until the 4th valid; o_calculate_end is a single pulse in the next cycle; o_done follows 7 cycles after it; o_err=0.
2. LUT load with xpe_mode=2, lut_load=1, and 32 words 0x000100+k with i_lut_vld toggling 1/0 -> 32 we pulses with addr 0..31 and wdata matching the words; RUN is entered only after addr 31 is written; no write is lost or duplicated.
3. out_cnt=0 with lut_load=0 -> the state goes IDLE→END directly; o_calc_en never rises; o_calculate_end pulses once; o_done arrives DRAIN_CYC+1 cycles after END.
4. Abort in RUN after 2 of 5 valids -> IDLE the next cycle; no calculate_end and no done; a new descriptor is accepted immediately and its count starts from 0.
5. Valid asserted in IDLE and during DRAIN -> o_err=1 and the counter is unchanged; o_err clears on the next descriptor accept.
6. Reset asserted mid-LUT at index 10 -> all outputs 0 except o_cfg_rdy=1; a fresh load restarts at addr 0.
